// File: rtl/jt5205_enc.sv
// jt5205_enc: OKI/Dialogic 4-bit ADPCM encoder, predictor and step index
// bit-compatible with the jt5205 decoder.
// Optional packed-byte output selected by `define JT5205_ENC_PACK_EN
// (two nibbles per byte, first sample in dout[7:4]); default is one nibble
// per output word in dout[3:0].
module jt5205_enc #(
  parameter int unsigned        STEP_INIT = 0,
  parameter logic signed [11:0] PRED_INIT = 12'sd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic signed [11:0] din,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [11:0] pred,
  output logic [5:0]         idx
);

  localparam int unsigned PCM_W   = 12;
  localparam int unsigned DIFF_W  = 13;
  localparam int unsigned SUM_W   = 14;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned STEP_W  = 11;
  localparam int unsigned DELTA_W = 12;
  localparam int unsigned ADJ_W   = 8;

  localparam logic signed [SUM_W-1:0] PRED_MAX = 14'sd2047;
  localparam logic signed [SUM_W-1:0] PRED_MIN = -14'sd2048;
  localparam logic signed [ADJ_W-1:0] IDX_MAX  = 8'sd48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIFF,
    S_B2,
    S_B1,
    S_B0,
    S_UPD
  } state_e;

  // 49-entry OKI step size table shared with the decoder
  function automatic logic [STEP_W-1:0] step_lut(input logic [IDX_W-1:0] i);
    case (i)
      6'd0:  step_lut = 11'd16;    6'd1:  step_lut = 11'd17;
      6'd2:  step_lut = 11'd19;    6'd3:  step_lut = 11'd21;
      6'd4:  step_lut = 11'd23;    6'd5:  step_lut = 11'd25;
      6'd6:  step_lut = 11'd28;    6'd7:  step_lut = 11'd31;
      6'd8:  step_lut = 11'd34;    6'd9:  step_lut = 11'd37;
      6'd10: step_lut = 11'd41;    6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;    6'd13: step_lut = 11'd55;
      6'd14: step_lut = 11'd60;    6'd15: step_lut = 11'd66;
      6'd16: step_lut = 11'd73;    6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;    6'd19: step_lut = 11'd97;
      6'd20: step_lut = 11'd107;   6'd21: step_lut = 11'd118;
      6'd22: step_lut = 11'd130;   6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;   6'd25: step_lut = 11'd173;
      6'd26: step_lut = 11'd190;   6'd27: step_lut = 11'd209;
      6'd28: step_lut = 11'd230;   6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;   6'd31: step_lut = 11'd307;
      6'd32: step_lut = 11'd337;   6'd33: step_lut = 11'd371;
      6'd34: step_lut = 11'd408;   6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;   6'd37: step_lut = 11'd544;
      6'd38: step_lut = 11'd598;   6'd39: step_lut = 11'd658;
      6'd40: step_lut = 11'd724;   6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;   6'd43: step_lut = 11'd963;
      6'd44: step_lut = 11'd1060;  6'd45: step_lut = 11'd1166;
      6'd46: step_lut = 11'd1282;  6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  state_e                    state_q, state_d;
  logic signed [PCM_W-1:0]   pred_q, pred_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      sign_q, sign_d;
  logic [DIFF_W-1:0]         mag_q, mag_d;
  logic [STEP_W-1:0]         st_q, st_d;
  logic [2:0]                bits_q, bits_d;
  logic [7:0]                dout_q, dout_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;
`ifdef JT5205_ENC_PACK_EN
  logic                      phase_q, phase_d;
  logic [3:0]                hi_q, hi_d;
`endif

  logic signed [DIFF_W-1:0]  diff;
  logic [DIFF_W-1:0]         diff_abs;
  logic [DIFF_W-1:0]         st_full, st_half, st_quarter;
  logic [DELTA_W-1:0]        delta;
  logic signed [SUM_W-1:0]   pred_sum;
  logic signed [PCM_W-1:0]   pred_clamp;
  logic signed [ADJ_W-1:0]   idx_adj;
  logic signed [ADJ_W-1:0]   idx_sum;
  logic [IDX_W-1:0]          idx_clamp;
  logic [3:0]                nib;

  // Datapath: difference, step fractions, reconstructed delta and clamps
  always_comb begin
    diff       = $signed({din[PCM_W-1], din}) - $signed({pred_q[PCM_W-1], pred_q});
    diff_abs   = diff[DIFF_W-1] ? $unsigned(-diff) : $unsigned(diff);
    st_full    = DIFF_W'(st_q);
    st_half    = DIFF_W'(st_q >> 1);
    st_quarter = DIFF_W'(st_q >> 2);
    delta      = DELTA_W'(st_q >> 3)
               + (bits_q[2] ? DELTA_W'(st_q)      : DELTA_W'(0))
               + (bits_q[1] ? DELTA_W'(st_q >> 1) : DELTA_W'(0))
               + (bits_q[0] ? DELTA_W'(st_q >> 2) : DELTA_W'(0));
    if (sign_q) begin
      pred_sum = $signed({{2{pred_q[PCM_W-1]}}, pred_q}) - $signed({2'b00, delta});
    end else begin
      pred_sum = $signed({{2{pred_q[PCM_W-1]}}, pred_q}) + $signed({2'b00, delta});
    end
    if (pred_sum > PRED_MAX) begin
      pred_clamp = 12'sd2047;
    end else if (pred_sum < PRED_MIN) begin
      pred_clamp = -12'sd2048;
    end else begin
      pred_clamp = pred_sum[PCM_W-1:0];
    end
    if (bits_q[2]) begin
      idx_adj = $signed({5'd0, bits_q[1:0], 1'b0}) + 8'sd2;
    end else begin
      idx_adj = -8'sd1;
    end
    idx_sum = $signed({2'b00, idx_q}) + idx_adj;
    if (idx_sum < 8'sd0) begin
      idx_clamp = 6'd0;
    end else if (idx_sum > IDX_MAX) begin
      idx_clamp = 6'd48;
    end else begin
      idx_clamp = idx_sum[IDX_W-1:0];
    end
    nib = {sign_q, bits_q};
  end

  // Next-state: conversion sequence and output handshake
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    idx_d       = idx_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    st_d        = st_q;
    bits_d      = bits_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
`ifdef JT5205_ENC_PACK_EN
    phase_d     = phase_q;
    hi_d        = hi_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        sign_d  = diff[DIFF_W-1];
        mag_d   = diff_abs;
        st_d    = step_lut(idx_q);
        bits_d  = 3'b000;
        state_d = S_B2;
      end
      S_B2: begin
        if (mag_q >= st_full) begin
          bits_d[2] = 1'b1;
          mag_d     = mag_q - st_full;
        end
        state_d = S_B1;
      end
      S_B1: begin
        if (mag_q >= st_half) begin
          bits_d[1] = 1'b1;
          mag_d     = mag_q - st_half;
        end
        state_d = S_B0;
      end
      S_B0: begin
        bits_d[0] = (mag_q >= st_quarter);
        state_d   = S_UPD;
      end
      S_UPD: begin
        pred_d  = pred_clamp;
        idx_d   = idx_clamp;
`ifdef JT5205_ENC_PACK_EN
        if (!phase_q) begin
          hi_d    = nib;
          phase_d = 1'b1;
        end else begin
          dout_d      = {hi_q, nib};
          out_valid_d = 1'b1;
          phase_d     = 1'b0;
        end
`else
        dout_d      = {4'b0000, nib};
        out_valid_d = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE) && !out_valid_d;
  end

  // State registers, advancing only on clock-enabled edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pred_q      <= PRED_INIT;
      idx_q       <= IDX_W'(STEP_INIT);
      sign_q      <= 1'b0;
      mag_q       <= '0;
      st_q        <= '0;
      bits_q      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef JT5205_ENC_PACK_EN
      phase_q     <= 1'b0;
      hi_q        <= '0;
`endif
    end else if (cen) begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      idx_q       <= idx_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      st_q        <= st_d;
      bits_q      <= bits_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef JT5205_ENC_PACK_EN
      phase_q     <= phase_d;
      hi_q        <= hi_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign pred      = pred_q;
  assign idx       = idx_q;

endmodule
